// File: rtl/seg_capture.sv
// seg_capture: decodes a multiplexed 7-segment display scan into debounced, handshaked frames (optional glyph-error reporting via SEG_CAPTURE_ERROR_EN)
module seg_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            segments_i,
  input  logic [DIGITS-1:0]     digit_enable_i,
  output logic [4*DIGITS-1:0]   frame_value_o,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic                  frame_overrun_o,
  output logic                  pattern_error_o,
  output logic [2:0]            error_digit_o
);
  localparam int SW = 7 + DIGITS;
  typedef enum logic {WAIT_STABLE, CAPTURED} state_t;
  state_t                state_q, state_d;
  logic [SW-1:0]         sample_q, sample_in;
  logic [7:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [4*DIGITS-1:0]   work_q, work_d, frame_q;
  logic                  valid_q, overrun_q;
  logic                  same, capture, full, xfer, bad;
  logic [3:0]            nib;
  logic [2:0]            idx;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0a;
      7'h03: decode = 5'h0b;
      7'h46: decode = 5'h0c;
      7'h21: decode = 5'h0d;
      7'h06: decode = 5'h0e;
      7'h0e: decode = 5'h0f;
      7'h7f: decode = 5'h00;
      default: decode = 5'h10;
    endcase
  endfunction

  // digit index of the sample currently held (one-hot strobe)
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) if (sample_q[i]) idx = 3'(i);
  end

  // stability tracking, per-sample capture FSM and working-buffer update
  always_comb begin
    sample_in = {segments_i, digit_enable_i};
    same      = $onehot(digit_enable_i) && (sample_in == sample_q);
    capture   = same && (state_q == WAIT_STABLE) && (cnt_q >= 8'(STABLE_CYCLES - 1));
    cnt_d     = !same ? 8'd0 : (cnt_q >= 8'(STABLE_CYCLES)) ? cnt_q : cnt_q + 8'd1;
    state_d   = !same ? WAIT_STABLE : capture ? CAPTURED : state_q;
    {bad, nib} = decode(sample_q[SW-1:DIGITS]);
    full      = &mask_q;
    xfer      = full && (!valid_q || frame_ready_i);
    work_d    = work_q;
    mask_d    = full ? '0 : mask_q;
    if (capture) begin
      work_d[4*int'(idx) +: 4] = bad ? 4'h0 : nib;
      mask_d[idx]              = 1'b1;
    end
  end

  // state registers, frame transfer/handshake and overrun detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WAIT_STABLE;
      sample_q  <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      work_q    <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_in;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      work_q    <= work_d;
      frame_q   <= xfer ? work_q : frame_q;
      valid_q   <= xfer ? 1'b1 : (valid_q && !frame_ready_i);
      overrun_q <= full && !xfer;
    end
  end

  assign frame_value_o   = frame_q;
  assign frame_valid_o   = valid_q;
  assign frame_overrun_o = overrun_q;

`ifdef SEG_CAPTURE_ERROR_EN
  logic       perr_q;
  logic [2:0] edig_q;
  // glyph-error pulse and sticky digit index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
      edig_q <= '0;
    end else begin
      perr_q <= capture && bad;
      edig_q <= (capture && bad) ? idx : edig_q;
    end
  end
  assign pattern_error_o = perr_q;
  assign error_digit_o   = edig_q;
`else
  assign pattern_error_o = 1'b0;
  assign error_digit_o   = 3'd0;
`endif
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: scoreboard bench for seg_capture frames, overruns and glyph errors
module tb_seg_capture;
`ifdef SEG_CAPTURE_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [6:0] G[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  segments_i;
  logic [7:0]  digit_enable_i;
  logic [31:0] frame_value_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic        frame_overrun_o;
  logic        pattern_error_o;
  logic [2:0]  error_digit_o;
  logic [31:0] q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ovr = 0;
  int          n_perr = 0;
  logic [2:0]  last_edig = 3'd0;

  seg_capture dut (
    .clk_i(clk_i), .rst_i(rst_i), .segments_i(segments_i), .digit_enable_i(digit_enable_i),
    .frame_value_o(frame_value_o), .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i),
    .frame_overrun_o(frame_overrun_o), .pattern_error_o(pattern_error_o), .error_digit_o(error_digit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops expected frames on each handshake, tallies pulses
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (frame_valid_o && frame_ready_i) begin
        if (q.size() == 0) chk("unexpected_frame", frame_value_o, 32'hxxxxxxxx);
        else chk("frame", frame_value_o, q.pop_front());
      end
      if (frame_overrun_o) n_ovr++;
      if (pattern_error_o) begin
        n_perr++;
        last_edig = error_digit_o;
      end
    end
  end

  task automatic drive(input logic [6:0] s, input logic [7:0] en, input int n);
    segments_i = s;
    digit_enable_i = en;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic dig(input int i, input logic [6:0] s, input int n);
    drive(s, 8'(1 << i), n);
  endtask

  task automatic scan_hex(input logic [31:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) dig(i, G[v[4*i +: 4]], 6);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk_i);
    chk({tag, "_value"}, frame_value_o, 32'h0);
    chk({tag, "_valid"}, {31'd0, frame_valid_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, frame_overrun_o}, 32'd0);
    chk({tag, "_perr"}, {31'd0, pattern_error_o}, 32'd0);
    chk({tag, "_edig"}, {29'd0, error_digit_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    segments_i = 7'h7f;
    digit_enable_i = 8'h00;
    frame_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    reset_check("reset");
    // plain scan, frame_valid for exactly one cycle with ready high
    q.push_back(32'h76543210);
    scan_hex(32'h76543210, 0, 7);
    chk("valid_after_transfer", {31'd0, frame_valid_o}, 32'd1);
    drive(7'h7f, 8'h00, 1);
    chk("valid_one_cycle", {31'd0, frame_valid_o}, 32'd0);
    drive(7'h7f, 8'h00, 2);
    // single-cycle glitch on digit 2 must not be captured
    q.push_back(32'hfedcba98);
    scan_hex(32'hfedcba98, 0, 1);
    dig(2, G[10], 2);
    dig(2, 7'h7e, 1);
    dig(2, G[10], 6);
    scan_hex(32'hfedcba98, 3, 7);
    drive(7'h7f, 8'h00, 3);
    chk("glitch_no_perr", 32'(n_perr), 32'd0);
    // stable invalid glyph on digit 5
    q.push_back(32'h76054321);
    scan_hex(32'h76054321, 0, 4);
    dig(5, 7'h7e, 6);
    scan_hex(32'h76054321, 6, 7);
    drive(7'h7f, 8'h00, 3);
    chk("invalid_perr_count", 32'(n_perr), ERR_EN ? 32'd1 : 32'd0);
    chk("invalid_edig", {29'd0, ERR_EN ? last_edig : error_digit_o}, ERR_EN ? 32'd5 : 32'd0);
    // consumer stalled: second frame dropped, first held
    frame_ready_i = 1'b0;
    q.push_back(32'h76543210);
    scan_hex(32'h76543210, 0, 7);
    scan_hex(32'hfedcba98, 0, 7);
    drive(7'h7f, 8'h00, 2);
    chk("overrun_count", 32'(n_ovr), 32'd1);
    chk("held_value", frame_value_o, 32'h76543210);
    chk("held_valid", {31'd0, frame_valid_o}, 32'd1);
    frame_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("valid_drop", {31'd0, frame_valid_o}, 32'd0);
    // multi-hot strobe with a different glyph is ignored
    q.push_back(32'h76543210);
    scan_hex(32'h76543210, 0, 6);
    drive(G[1], 8'h03, 10);
    scan_hex(32'h76543210, 7, 7);
    drive(7'h7f, 8'h00, 3);
    // reset mid-frame discards captured digits 4..7
    scan_hex(32'h55555555, 4, 7);
    rst_i = 1'b1;
    drive(7'h7f, 8'h00, 2);
    rst_i = 1'b0;
    reset_check("midreset");
    q.push_back(32'h89abcdef);
    scan_hex(32'h89abcdef, 0, 7);
    drive(7'h7f, 8'h00, 3);
    // recapture of a digit within a frame overwrites it
    q.push_back(32'h76543210);
    dig(0, G[3], 6);
    scan_hex(32'h76543210, 0, 7);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk_i);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_overrun_count", 32'(n_ovr), 32'd1);
    chk("final_perr_count", 32'(n_perr), ERR_EN ? 32'd1 : 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
